// File: rtl/cobra_stim_seq.sv
// Table-driven stimulus sequencer for the Cobra core.
// Replays loaded steps on IN/RST and scores OUT against expected values.
module cobra_stim_seq #(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 16,
  parameter  int HOLD_W = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [AW-1:0]     WR_ADDR,
  input  logic [WIDTH-1:0]  WR_IN,
  input  logic              WR_RST,
  input  logic [HOLD_W-1:0] WR_HOLD,
  input  logic [WIDTH-1:0]  WR_EXP,
  input  logic              WR_CHK,
  input  logic [AW:0]       LEN,
  input  logic              START,
  output logic [WIDTH-1:0]  DUT_IN,
  output logic              DUT_RST,
  input  logic [WIDTH-1:0]  DUT_OUT,
  output logic              BUSY,
  output logic              DONE,
  output logic [AW-1:0]     STEP,
  output logic [AW:0]       ERR_CNT,
  output logic [AW-1:0]     FIRST_ERR,
  output logic [WIDTH-1:0]  FIRST_OBS
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [AW:0] LMAX = (AW+1)'(DEPTH);

  state_t            state_q;
  logic [WIDTH-1:0]  mem_in_q   [DEPTH];
  logic              mem_rst_q  [DEPTH];
  logic [HOLD_W-1:0] mem_hold_q [DEPTH];
  logic [WIDTH-1:0]  mem_exp_q  [DEPTH];
  logic              mem_chk_q  [DEPTH];

  logic [WIDTH-1:0]  dut_in_q;
  logic              dut_rst_q;
  logic              busy_q;
  logic              done_q;
  logic [AW-1:0]     step_q;
  logic [AW:0]       err_cnt_q;
  logic [AW-1:0]     first_err_q;
  logic [WIDTH-1:0]  first_obs_q;
  logic [HOLD_W-1:0] cnt_q;
  logic [AW:0]       len_q;

  logic [AW:0]       len_d;
  logic [AW:0]       step_inc_d;
  logic [AW-1:0]     step_nxt_d;
  logic              miss_d;

  function automatic logic [HOLD_W-1:0] hold1(input logic [HOLD_W-1:0] h);
    return (h == '0) ? HOLD_W'(1) : h;
  endfunction

  assign len_d      = (LEN > LMAX) ? LMAX : LEN;
  assign step_inc_d = {1'b0, step_q} + (AW+1)'(1);
  assign step_nxt_d = step_inc_d[AW-1:0];
  assign miss_d     = mem_chk_q[step_q] && (DUT_OUT != mem_exp_q[step_q]);

  // Table is plain storage: no reset, loadable only while idle.
  always_ff @(posedge CLK) begin
    if (!RST && WR_EN && state_q == IDLE) begin
      mem_in_q[WR_ADDR]   <= WR_IN;
      mem_rst_q[WR_ADDR]  <= WR_RST;
      mem_hold_q[WR_ADDR] <= WR_HOLD;
      mem_exp_q[WR_ADDR]  <= WR_EXP;
      mem_chk_q[WR_ADDR]  <= WR_CHK;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      dut_in_q    <= '0;
      dut_rst_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      step_q      <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      first_obs_q <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (START) begin
            err_cnt_q   <= '0;
            first_err_q <= '0;
            first_obs_q <= '0;
            len_q       <= len_d;
            if (len_d != '0) begin
              state_q   <= RUN;
              busy_q    <= 1'b1;
              step_q    <= '0;
              dut_in_q  <= mem_in_q[0];
              dut_rst_q <= mem_rst_q[0];
              cnt_q     <= hold1(mem_hold_q[0]);
            end else begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (cnt_q == HOLD_W'(1)) begin
            if (miss_d) begin
              err_cnt_q <= err_cnt_q + (AW+1)'(1);
              if (err_cnt_q == '0) begin
                first_err_q <= step_q;
                first_obs_q <= DUT_OUT;
              end
            end
            // Last compare of the run ends the burst; otherwise advance.
            if (step_inc_d == len_q) begin
              state_q   <= FIN;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              dut_in_q  <= '0;
              dut_rst_q <= 1'b0;
            end else begin
              step_q    <= step_nxt_d;
              dut_in_q  <= mem_in_q[step_nxt_d];
              dut_rst_q <= mem_rst_q[step_nxt_d];
              cnt_q     <= hold1(mem_hold_q[step_nxt_d]);
            end
          end else begin
            cnt_q <= cnt_q - HOLD_W'(1);
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DUT_IN    = dut_in_q;
  assign DUT_RST   = dut_rst_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign STEP      = step_q;
  assign ERR_CNT   = err_cnt_q;
  assign FIRST_ERR = first_err_q;
  assign FIRST_OBS = first_obs_q;

endmodule

// File: tb/tb_cobra_stim_seq.sv
// Bench for cobra_stim_seq: directed scenarios plus random tables,
// scored against a per-cycle expectation built from the step table.
module tb_cobra_stim_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        WR_EN;
  logic [3:0]  WR_ADDR;
  logic [31:0] WR_IN;
  logic        WR_RST;
  logic [7:0]  WR_HOLD;
  logic [31:0] WR_EXP;
  logic        WR_CHK;
  logic [4:0]  LEN;
  logic        START;
  logic [31:0] DUT_IN;
  logic        DUT_RST;
  logic [31:0] DUT_OUT;
  logic        BUSY;
  logic        DONE;
  logic [3:0]  STEP;
  logic [4:0]  ERR_CNT;
  logic [3:0]  FIRST_ERR;
  logic [31:0] FIRST_OBS;

  logic [31:0] mask;
  int          errors = 0;
  int          checks = 0;

  logic [31:0] m_in   [16];
  logic        m_rst  [16];
  logic [7:0]  m_hold [16];
  logic [31:0] m_exp  [16];
  logic        m_chk  [16];

  assign DUT_OUT = DUT_IN ^ mask;

  cobra_stim_seq dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
    .WR_IN(WR_IN), .WR_RST(WR_RST), .WR_HOLD(WR_HOLD),
    .WR_EXP(WR_EXP), .WR_CHK(WR_CHK), .LEN(LEN), .START(START),
    .DUT_IN(DUT_IN), .DUT_RST(DUT_RST), .DUT_OUT(DUT_OUT),
    .BUSY(BUSY), .DONE(DONE), .STEP(STEP), .ERR_CNT(ERR_CNT),
    .FIRST_ERR(FIRST_ERR), .FIRST_OBS(FIRST_OBS)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] vin, input logic r,
                    input logic [7:0] h, input logic [31:0] e,
                    input logic c);
    WR_EN = 1'b1; WR_ADDR = 4'(a); WR_IN = vin; WR_RST = r;
    WR_HOLD = h; WR_EXP = e; WR_CHK = c;
    @(negedge CLK);
    WR_EN = 1'b0;
    m_in[a] = vin; m_rst[a] = r; m_hold[a] = h; m_exp[a] = e; m_chk[a] = c;
  endtask

  function automatic logic [63:0] obs_word();
    return 64'({BUSY, DONE, DUT_RST, STEP, DUT_IN});
  endfunction

  // Expected run: each step k contributes max(hold,1) cycles of its
  // stimulus; the core's reply is IN^mask, scored once per step.
  task automatic run_seq(input int len, input logic [31:0] msk,
                         input bit disturb);
    logic [63:0] q[$];
    int n, h, errs, fe;
    logic [31:0] fo, o;
    n = (len > 16) ? 16 : len;
    errs = 0; fe = 0; fo = '0;
    for (int k = 0; k < n; k++) begin
      h = (m_hold[k] == 0) ? 1 : int'(m_hold[k]);
      for (int c = 0; c < h; c++)
        q.push_back(64'({1'b1, 1'b0, m_rst[k], 4'(k), m_in[k]}));
      o = m_in[k] ^ msk;
      if (m_chk[k] && o != m_exp[k]) begin
        if (errs == 0) begin fe = k; fo = o; end
        errs++;
      end
    end
    mask = msk;
    LEN = 5'(len);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    foreach (q[i]) begin
      check("cycle", obs_word(), q[i]);
      if (disturb) begin
        WR_EN = (i == 1);
        WR_ADDR = 4'd2; WR_IN = 32'hDEAD; WR_RST = 1'b1;
        WR_HOLD = 8'd9; WR_EXP = 32'h1234; WR_CHK = 1'b1;
        START = (i == 1) || (i == 2);
      end
      @(negedge CLK);
      WR_EN = 1'b0;
      START = 1'b0;
    end
    check("done", 64'({BUSY, DONE, DUT_RST, DUT_IN}), 64'({3'b010, 32'h0}));
    check("err_cnt", 64'(ERR_CNT), 64'(errs));
    if (errs != 0) begin
      check("first_err", 64'(FIRST_ERR), 64'(fe));
      check("first_obs", 64'(FIRST_OBS), 64'(fo));
    end
    @(negedge CLK);
    check("done_pulse", 64'({BUSY, DONE}), 64'(0));
  endtask

  task automatic load_scn1();
    wr(0, 32'h0A, 1'b1, 8'd1, 32'h0,  1'b0);
    wr(1, 32'h0A, 1'b0, 8'd4, 32'h0A, 1'b1);
    wr(2, 32'h05, 1'b0, 8'd2, 32'h05, 1'b1);
  endtask

  initial begin
    RST = 1'b1; WR_EN = 1'b0; WR_ADDR = '0; WR_IN = '0; WR_RST = 1'b0;
    WR_HOLD = '0; WR_EXP = '0; WR_CHK = 1'b0; LEN = '0; START = 1'b0;
    mask = '0;
    @(negedge CLK);
    @(negedge CLK);
    check("reset", 64'({BUSY, DONE, DUT_RST, STEP, DUT_IN}), 64'(0));
    check("reset_err", 64'({ERR_CNT, FIRST_ERR, FIRST_OBS}), 64'(0));
    RST = 1'b0;
    for (int a = 0; a < 16; a++)
      wr(a, $urandom, 1'($urandom), 8'($urandom_range(0, 3)),
         $urandom, 1'($urandom));

    load_scn1();
    run_seq(3, 32'h0, 1'b0);
    run_seq(3, 32'h1, 1'b0);
    repeat (3) @(negedge CLK);
    check("err_hold", 64'({ERR_CNT, FIRST_ERR, FIRST_OBS}),
          64'({5'd2, 4'd1, 32'h0B}));

    // Mid-run reset during step 1
    mask = '0; LEN = 5'd3; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    check("rst_step1", 64'(STEP), 64'(1));
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("rst_out", obs_word(), 64'(0));
    check("rst_err", 64'({ERR_CNT, FIRST_ERR, FIRST_OBS}), 64'(0));
    @(negedge CLK);
    check("rst_nodone", 64'({BUSY, DONE}), 64'(0));
    run_seq(3, 32'h0, 1'b0);

    // Writes and STARTs while busy must be ignored
    run_seq(3, 32'h1, 1'b1);
    run_seq(3, 32'h1, 1'b0);

    wr(0, 32'h11, 1'b0, 8'd0, 32'h11, 1'b1);
    wr(1, 32'h22, 1'b1, 8'd0, 32'h20, 1'b1);
    run_seq(2, 32'h0, 1'b0);
    run_seq(0, 32'h0, 1'b0);
    run_seq(20, 32'h0, 1'b0);

    for (int r = 0; r < 30; r++) begin
      for (int j = 0; j < 3; j++) begin
        automatic logic [31:0] v = $urandom;
        automatic logic [31:0] e = ($urandom_range(0, 1) == 1) ? v : $urandom;
        wr(int'($urandom_range(0, 15)), v, 1'($urandom),
           8'($urandom_range(0, 4)), e, 1'($urandom));
      end
      run_seq(int'($urandom_range(0, 20)),
              ($urandom_range(0, 2) == 0) ? 32'($urandom) : 32'h0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cobra_stim_seq.md
# cobra_stim_seq

Parametrised, synthesizable stimulus sequencer for the Cobra core. It replaces hand-written per-value driver tasks with a loadable table of steps. Each step drives the core's `IN` and `RST` for a programmable number of cycles, then optionally compares `OUT` against an expected value. It sits between a host/bench load port and the core, and reports completion, the error count and the first failing step.

## Interface
Parameters:
- `WIDTH`, 32, width of core `IN`/`OUT` words.
- `DEPTH`, 16, number of step entries (power of two, ≥2).
- `HOLD_W`, 8, width of per-step hold count.
- `AW`, derived, `$clog2(DEPTH)`.

Ports (reset is synchronous, active-high):
- `CLK`  in  1  single clock.
- `RST`  in  1  synchronous active-high reset.
- `WR_EN`  in  1  write one step entry.
- `WR_ADDR`  in  AW  entry index.
- `WR_IN`  in  WIDTH  value driven on core `IN` during the step.
- `WR_RST`  in  1  drive core reset during the step.
- `WR_HOLD`  in  HOLD_W  cycles the step lasts; 0 is treated as 1.
- `WR_EXP`  in  WIDTH  expected core `OUT` at end of step.
- `WR_CHK`  in  1  enable the comparison for this step.
- `LEN`  in  AW+1  number of steps to run; values above DEPTH clamp to DEPTH.
- `START`  in  1  begin a run.
- `DUT_IN`  out  WIDTH  to core `IN`.
- `DUT_RST`  out  1  to core `RST`.
- `DUT_OUT`  in  WIDTH  from core `OUT`.
- `BUSY`  out  1  run in progress.
- `DONE`  out  1  one-cycle pulse at end of run.
- `STEP`  out  AW  index of current step.
- `ERR_CNT`  out  AW+1  number of failed comparisons in the last run.
- `FIRST_ERR`  out  AW  step index of the first failure; valid when `ERR_CNT`≠0.
- `FIRST_OBS`  out  WIDTH  `DUT_OUT` observed at the first failure.

## Operation
- Step memory is DEPTH × (WIDTH+1+HOLD_W+WIDTH+1) registers with an asynchronous read and no reset. Contents survive `RST`.
- A write with `WR_EN`=1 takes effect at the next edge, only in IDLE. Writes while `BUSY`=1 are ignored.
- FSM states are IDLE, RUN and FIN.
  - IDLE: `START`=1 and clamped LEN≠0 → RUN. Clears `ERR_CNT`, `FIRST_ERR` and `FIRST_OBS`. Loads step 0: `DUT_IN`, `DUT_RST`, `STEP`=0, and hold counter = max(hold,1).
  - IDLE: `START`=1 and LEN=0 → FIN. Clears the error outputs.
  - RUN: the hold counter decrements each cycle. On the cycle where the counter is 1 (last cycle of the step), the edge samples `DUT_OUT`. If CHK=1 and `DUT_OUT`≠EXP, then `ERR_CNT`+=1, and if this is the first failure, `FIRST_ERR`=`STEP` and `FIRST_OBS`=`DUT_OUT`. The same edge loads step `STEP`+1, or goes → FIN if `STEP`+1 = LEN.
  - FIN: `DONE`=1 for exactly this cycle, `DUT_IN`=0, `DUT_RST`=0 → IDLE.
- `START` in RUN or FIN is ignored. After a run, `ERR_CNT`, `FIRST_ERR` and `FIRST_OBS` hold until the next accepted `START` or `RST`.
- `ERR_CNT` cannot overflow because its maximum is DEPTH.
- `DUT_IN`, `DUT_RST`, `BUSY`, `DONE` and `STEP` are all registered outputs. There are no combinational paths from inputs to outputs.

## Timing
- Reset values: state IDLE, `DUT_IN`=0, `DUT_RST`=0, `BUSY`=0, `DONE`=0, `STEP`=0, `ERR_CNT`=0, `FIRST_ERR`=0, `FIRST_OBS`=0.
- `START` sampled at edge E0 → from E0: `BUSY`=1, and `DUT_IN`/`DUT_RST` carry step 0.
- Step k occupies H_k = max(hold_k,1) cycles. `BUSY` stays high for ΣH_k cycles.
- The compare for step k samples at the edge that ends its last cycle, so `DUT_OUT` must be valid in that cycle.
- `DONE` goes high the cycle after the last compare edge, and `BUSY` is low in that same cycle. `ERR_CNT` is final when `DONE`=1.
- LEN=0: `DONE`=1 in the cycle after E0, and `BUSY` never rises.
- `RST`=1 at any edge, including mid-run: all outputs return to their reset values after that edge, with no `DONE` pulse. `RST` has priority over `START`, `WR_EN` and the FSM.
- Back-to-back runs: `START` is accepted at the FIN→IDLE edge+1 at the earliest, so there is a minimum of one IDLE cycle between runs.

## Test plan
- Load 3 steps: (0x0A, rst=1, hold=1, chk=0), (0x0A, rst=0, hold=4, exp=0x0A, chk=1), (0x05, hold=2, exp=0x05, chk=1). Set LEN=3, START, with the bench looping `DUT_OUT`=`DUT_IN` → `DUT_RST`=1 for 1 cycle, `BUSY` high 7 cycles, `DONE` pulse, `ERR_CNT`=0.
- Same table with `DUT_OUT`=`DUT_IN`^1 → `ERR_CNT`=2, `FIRST_ERR`=1, `FIRST_OBS`=0x0B.
- Two steps with hold=0, LEN=2 → `BUSY` exactly 2 cycles, `STEP` 0 then 1. LEN=0 → `DONE` the cycle after START with `BUSY` never high. LEN=20 with DEPTH=16 → 16 steps run.
- Assert `RST` during step 1 of the first scenario → next cycle `BUSY`=0, `DUT_IN`=0, `DUT_RST`=0, no `DONE`. Re-START → full 7-cycle replay with identical results, showing memory is retained.
- `WR_EN` to entry 2 and `START` pulses while `BUSY`=1 → entry unchanged and the run is not restarted. `ERR_CNT` of a failing run persists through IDLE until the next START.
